// File: rtl/data_mem_responder_if.sv
// CPU <-> data-memory bus: request, store/load data, stall and error handshake.
interface data_mem_responder_if;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        mem_err;

  modport master (
    output mem_ren, mem_wen, mem_addr, mem_wdata,
    input  mem_rdata, mem_stall, mem_err
  );

  modport slave (
    input  mem_ren, mem_wen, mem_addr, mem_wdata,
    output mem_rdata, mem_stall, mem_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data RAM responder with programmable wait states, pipeline stall,
// address-error pulse and a combinational debug read port.
//   state | meaning
//   IDLE  | waiting for a request; captures it on arrival
//   BUSY  | wait states counting down on the captured request
//   DONE  | access committed; stall low, result valid for one cycle
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  data_mem_responder_if.slave   bus,
  input  logic [ADDR_WIDTH-1:0] debug_addr,
  output logic [31:0]           debug_data
);

  localparam int         DEPTH  = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  ren_q, ren_d;
  logic                  wen_q, wen_d;
  logic                  lerr_q, lerr_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [31:0] mem_q [DEPTH];

  logic                  req;
  logic                  is_idle;
  logic [ADDR_WIDTH-1:0] live_idx;
  logic                  live_err;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic [31:0]           acc_wdata;
  logic                  acc_ren;
  logic                  acc_wen;
  logic                  acc_err;
  logic                  commit;
  logic                  wr_en;

  assign req      = bus.mem_ren | bus.mem_wen;
  assign is_idle  = (state_q == S_IDLE);
  assign live_idx = bus.mem_addr[ADDR_WIDTH+1:2];
  assign live_err = (|bus.mem_addr[1:0]) | (|bus.mem_addr[31:ADDR_WIDTH+2]);

  // With zero wait states the commit edge is the request edge, so use live inputs there.
  assign acc_idx   = is_idle ? live_idx      : idx_q;
  assign acc_wdata = is_idle ? bus.mem_wdata : wdata_q;
  assign acc_ren   = is_idle ? bus.mem_ren   : ren_q;
  assign acc_wen   = is_idle ? bus.mem_wen   : wen_q;
  assign acc_err   = is_idle ? live_err      : lerr_q;

  assign commit = (is_idle && req && (WAIT_CYCLES == 0)) ||
                  ((state_q == S_BUSY) && (cnt_q == 4'd1));
  assign wr_en  = commit & acc_wen & ~acc_err & ~rst;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    ren_d   = ren_q;
    wen_d   = wen_q;
    lerr_d  = lerr_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          idx_d   = live_idx;
          wdata_d = bus.mem_wdata;
          ren_d   = bus.mem_ren;
          wen_d   = bus.mem_wen;
          lerr_d  = live_err;
          if (WAIT_CYCLES == 0) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = WAIT_L;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (commit) begin
      if (acc_ren) rdata_d = acc_err ? 32'd0 : mem_q[acc_idx];
      err_d = acc_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      lerr_q  <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      lerr_q  <= lerr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[acc_idx] <= acc_wdata;
  end

  assign bus.mem_rdata = rdata_q;
  assign bus.mem_err   = err_q;
  assign bus.mem_stall = req & (state_q != S_DONE);
  assign debug_data    = mem_q[debug_addr];

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances (0, 1 and 3 wait states)
// driven one at a time, with a read-data/error scoreboard checked in each DONE cycle.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          sel = 1;
  logic        ren_r = 1'b0, wen_r = 1'b0;
  logic [31:0] addr_r = 32'd0, wdata_r = 32'd0;
  logic [7:0]  dbg_a = 8'd0;

  data_mem_responder_if bus0 ();
  data_mem_responder_if bus1 ();
  data_mem_responder_if bus2 ();
  logic [31:0] dbg0, dbg1, dbg2;

  assign bus0.mem_ren   = (sel == 0) & ren_r;
  assign bus0.mem_wen   = (sel == 0) & wen_r;
  assign bus0.mem_addr  = addr_r;
  assign bus0.mem_wdata = wdata_r;
  assign bus1.mem_ren   = (sel == 1) & ren_r;
  assign bus1.mem_wen   = (sel == 1) & wen_r;
  assign bus1.mem_addr  = addr_r;
  assign bus1.mem_wdata = wdata_r;
  assign bus2.mem_ren   = (sel == 2) & ren_r;
  assign bus2.mem_wen   = (sel == 2) & wen_r;
  assign bus2.mem_addr  = addr_r;
  assign bus2.mem_wdata = wdata_r;

  data_mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .bus(bus0), .debug_addr(dbg_a), .debug_data(dbg0));
  data_mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .bus(bus1), .debug_addr(dbg_a), .debug_data(dbg1));
  data_mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst), .bus(bus2), .debug_addr(dbg_a), .debug_data(dbg2));

  logic        cur_stall, cur_err;
  logic [31:0] cur_rdata, cur_dbg;
  always_comb begin
    cur_stall = bus1.mem_stall;
    cur_err   = bus1.mem_err;
    cur_rdata = bus1.mem_rdata;
    cur_dbg   = dbg1;
    case (sel)
      0: begin
        cur_stall = bus0.mem_stall; cur_err = bus0.mem_err;
        cur_rdata = bus0.mem_rdata; cur_dbg = dbg0;
      end
      2: begin
        cur_stall = bus2.mem_stall; cur_err = bus2.mem_err;
        cur_rdata = bus2.mem_rdata; cur_dbg = dbg2;
      end
      default: ;
    endcase
  end

  int n_cmp  = 0;
  int n_fail = 0;
  int waits[3] = '{0, 1, 3};
  logic [31:0] mdl [3][256];
  logic [31:0] exp_last [3];
  logic [31:0] exp_rd_q[$];
  logic        exp_er_q[$];
  int          last_done_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a posedge; returns just after the posedge ending the access
  // (or the following idle cycle when rel is set).
  task automatic do_access(input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic rel);
    logic        e;
    logic [7:0]  idx;
    logic [31:0] exp_rd;
    int          n;
    e   = (a[1:0] != 2'b00) || (a[31:10] != 22'd0);
    idx = a[9:2];
    exp_rd = r ? (e ? 32'd0 : mdl[sel][idx]) : exp_last[sel];
    if (w && !e) mdl[sel][idx] = d;
    exp_last[sel] = exp_rd;
    exp_rd_q.push_back(exp_rd);
    exp_er_q.push_back(e);

    ren_r = r; wen_r = w; addr_r = a; wdata_r = d;
    n = 0;
    @(negedge clk);
    while (cur_stall === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("stall_cycles", 32'(n), 32'(1 + waits[sel]));
    last_done_cyc = cyc;
    chk("done_rdata", cur_rdata, exp_rd_q.pop_front());
    chk("done_err", {31'd0, cur_err}, {31'd0, exp_er_q.pop_front()});
    @(posedge clk); #1;
    if (rel) begin
      ren_r = 1'b0; wen_r = 1'b0;
      @(negedge clk);
      chk("err_cleared", {31'd0, cur_err}, 32'd0);
      chk("rdata_hold", cur_rdata, exp_last[sel]);
      @(posedge clk); #1;
    end
  endtask

  task automatic dbg_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    dbg_a = a;
    #1;
    chk(tag, cur_dbg, exp);
  endtask

  int t0;

  initial begin
    for (int s = 0; s < 3; s++) exp_last[s] = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("reset_rdata", cur_rdata, 32'd0);
      chk("reset_err", {31'd0, cur_err}, 32'd0);
      chk("reset_stall", {31'd0, cur_stall}, 32'd0);
    end
    @(posedge clk); #1;

    // 1 wait state: write then read back
    sel = 1;
    do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1);
    dbg_chk("t1_debug", 8'd4, 32'hDEADBEEF);
    do_access(1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
    chk("t2_rdata", cur_rdata, 32'hDEADBEEF);

    // zero wait states, back-to-back write then read
    sel = 0;
    t0 = cyc;
    do_access(1'b0, 1'b1, 32'h0, 32'h1, 1'b0);
    do_access(1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
    chk("t3_latency", 32'(last_done_cyc - t0), 32'd3);
    chk("t3_rdata", cur_rdata, 32'h1);

    // error accesses
    sel = 1;
    do_access(1'b0, 1'b1, 32'h13, 32'h55, 1'b1);
    do_access(1'b1, 1'b0, 32'h4000_0000, 32'h0, 1'b1);
    dbg_chk("t4_ram4_kept", 8'd4, 32'hDEADBEEF);
    chk("t4_rdata_zero", cur_rdata, 32'd0);

    // simultaneous read and write: read-before-write
    do_access(1'b0, 1'b1, 32'h8, 32'hA, 1'b1);
    do_access(1'b1, 1'b1, 32'h8, 32'hB, 1'b1);
    chk("t5_rdata_old", cur_rdata, 32'hA);
    dbg_chk("t5_debug_new", 8'd2, 32'hB);

    // 3 wait states, reset during the second BUSY cycle
    sel = 2;
    do_access(1'b0, 1'b1, 32'h20, 32'h12345678, 1'b1);
    do_access(1'b1, 1'b0, 32'h20, 32'h0, 1'b1);
    ren_r = 1'b0; wen_r = 1'b1; addr_r = 32'h20; wdata_r = 32'h77;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_busy_stall", {31'd0, cur_stall}, 32'd1);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wen_r = 1'b0;
    for (int s = 0; s < 3; s++) exp_last[s] = 32'd0;
    @(negedge clk);
    chk("t6_stall_after_rst", {31'd0, cur_stall}, 32'd0);
    chk("t6_rdata_after_rst", cur_rdata, 32'd0);
    chk("t6_err_after_rst", {31'd0, cur_err}, 32'd0);
    dbg_chk("t6_ram8_kept", 8'd8, 32'h12345678);
    @(posedge clk); #1;
    do_access(1'b1, 1'b0, 32'h20, 32'h0, 1'b1);
    chk("t6_read_after", cur_rdata, 32'h12345678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
